// File: rtl/mem_access_unit.sv
// Load/store unit: turns one MIPS memory opcode into a single word-aligned Avalon
// transaction, with lane steering for stores and extraction/merge for loads.
module mem_access_unit #(
  parameter int unsigned RDATA_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [5:0]  opcode,
  input  logic [31:0] eff_addr,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        done,
  output logic        addr_error,
  output logic [31:0] load_result,
  output logic [31:0] bus_address,
  output logic        bus_read,
  output logic        bus_write,
  output logic [3:0]  bus_byteenable,
  output logic [31:0] bus_writedata,
  input  logic        bus_waitrequest,
  input  logic [31:0] bus_readdata
);

  typedef enum logic [5:0] {
    OP_LB  = 6'b100000,
    OP_LH  = 6'b100001,
    OP_LWL = 6'b100010,
    OP_LW  = 6'b100011,
    OP_LBU = 6'b100100,
    OP_LHU = 6'b100101,
    OP_LWR = 6'b100110,
    OP_SB  = 6'b101000,
    OP_SH  = 6'b101001,
    OP_SW  = 6'b101011
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_RDATA,
    S_DONE,
    S_ERR
  } state_e;

  state_e      state;
  op_e         op_in;
  op_e         op_q;
  logic [1:0]  n_q;
  logic [31:0] rt_q;
  logic [31:0] word_q;
  logic        is_load_q;

  // Request decode, evaluated against the live inputs while IDLE.
  logic        req_ok;
  logic        req_load;
  logic [3:0]  req_be;
  logic [31:0] req_wd;
  logic [1:0]  a;

  assign op_in = op_e'(opcode);
  assign a     = eff_addr[1:0];

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    req_ok   = 1'b1;
    req_load = 1'b1;
    req_be   = 4'b1111;
    req_wd   = '0;
    case (op_in)
      OP_LB, OP_LBU: ;
      OP_LH, OP_LHU: req_ok = ~a[0];
      OP_LW:         req_ok = (a == 2'd0);
      OP_LWL:        req_be = 4'b1111 << a;
      OP_LWR:        req_be = 4'b1111 >> (2'd3 - a);
      OP_SB: begin
        req_load = 1'b0;
        req_be   = 4'b0001 << a;
        req_wd   = {24'd0, rt_data[7:0]} << {~a, 3'b000};
      end
      OP_SH: begin
        req_load = 1'b0;
        req_ok   = ~a[0];
        req_be   = a[1] ? 4'b1100 : 4'b0011;
        req_wd   = a[1] ? {16'd0, rt_data[15:0]} : {rt_data[15:0], 16'd0};
      end
      OP_SW: begin
        req_load = 1'b0;
        req_ok   = (a == 2'd0);
        req_wd   = rt_data;
      end
      default: req_ok = 1'b0;
    endcase
  end

  // Load extraction from the captured word; lane k sits at bits [31-8k -: 8].
  logic [4:0]  sh_lo;
  logic [4:0]  sh_hi;
  logic [31:0] word_shr;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_value;

  assign sh_lo    = {n_q, 3'b000};
  assign sh_hi    = {~n_q, 3'b000};
  assign word_shr = word_q >> sh_hi;
  assign byte_v   = word_shr[7:0];
  assign half_v   = n_q[1] ? word_q[15:0] : word_q[31:16];

  always_comb begin
    load_value = word_q;
    case (op_q)
      OP_LB:  load_value = {{24{byte_v[7]}}, byte_v};
      OP_LBU: load_value = {24'd0, byte_v};
      OP_LH:  load_value = {{16{half_v[15]}}, half_v};
      OP_LHU: load_value = {16'd0, half_v};
      OP_LWL: load_value = (word_q << sh_lo) | (rt_q & ~(32'hFFFF_FFFF << sh_lo));
      OP_LWR: load_value = word_shr | (rt_q & ~(32'hFFFF_FFFF >> sh_hi));
      default: load_value = word_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      op_q           <= OP_LW;
      n_q            <= '0;
      rt_q           <= '0;
      word_q         <= '0;
      is_load_q      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      addr_error     <= 1'b0;
      load_result    <= '0;
      bus_address    <= '0;
      bus_read       <= 1'b0;
      bus_write      <= 1'b0;
      bus_byteenable <= '0;
      bus_writedata  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      done       <= 1'b0;
      addr_error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (op_valid) begin
            op_q        <= op_in;
            n_q         <= a;
            rt_q        <= rt_data;
            is_load_q   <= req_load;
            bus_address <= {eff_addr[31:2], 2'b00};
            busy        <= 1'b1;
            if (req_ok) begin
              state          <= S_ACCESS;
              bus_read       <= req_load;
              bus_write      <= ~req_load;
              bus_byteenable <= req_be;
              bus_writedata  <= req_wd;
            end else begin
              state <= S_ERR;
            end
          end
        end
        S_ACCESS: begin
          if (!bus_waitrequest) begin
            bus_read       <= 1'b0;
            bus_write      <= 1'b0;
            bus_byteenable <= '0;
            bus_writedata  <= '0;
            if (bus_read && RDATA_LAT != 0) begin
              state <= S_RDATA;
            end else begin
              if (bus_read) word_q <= bus_readdata;
              state <= S_DONE;
            end
          end
        end
        S_RDATA: begin
          word_q <= bus_readdata;
          state  <= S_DONE;
        end
        S_DONE: begin
          if (is_load_q) load_result <= load_value;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        S_ERR: begin
          addr_error <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: hand-computed lanes, data and latencies,
// including waitrequest stalls, misalignment errors and mid-transaction reset.
module tb_mem_access_unit;

  localparam logic [5:0] LB = 6'b100000, LH = 6'b100001, LWL = 6'b100010,
                         LW = 6'b100011, LBU = 6'b100100, LHU = 6'b100101,
                         LWR = 6'b100110, SB = 6'b101000, SH = 6'b101001,
                         SW = 6'b101011;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [5:0]  opcode;
  logic [31:0] eff_addr;
  logic [31:0] rt_data;
  logic        busy;
  logic        done;
  logic        addr_error;
  logic [31:0] load_result;
  logic [31:0] bus_address;
  logic        bus_read;
  logic        bus_write;
  logic [3:0]  bus_byteenable;
  logic [31:0] bus_writedata;
  logic        bus_waitrequest;
  logic [31:0] bus_readdata;

  int n_checks = 0;
  int n_fail   = 0;

  // Observations gathered by issue()
  int          lat;
  int          rd_cyc;
  int          wr_cyc;
  logic [3:0]  be_seen;
  logic [31:0] wd_seen;
  logic [31:0] ad_seen;
  logic        saw_done;
  logic        saw_err;
  logic        stable;
  logic        pulse_ok;
  logic        quiet;
  logic [31:0] res_seen;

  always #5 clk = ~clk;

  mem_access_unit #(.RDATA_LAT(1)) dut (
    .clk             (clk),
    .reset           (reset),
    .op_valid        (op_valid),
    .opcode          (opcode),
    .eff_addr        (eff_addr),
    .rt_data         (rt_data),
    .busy            (busy),
    .done            (done),
    .addr_error      (addr_error),
    .load_result     (load_result),
    .bus_address     (bus_address),
    .bus_read        (bus_read),
    .bus_write       (bus_write),
    .bus_byteenable  (bus_byteenable),
    .bus_writedata   (bus_writedata),
    .bus_waitrequest (bus_waitrequest),
    .bus_readdata    (bus_readdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issues one op; lat counts clock edges from the op_valid edge to done/addr_error.
  // poke drives a second request during the first busy cycle, which must be ignored.
  task automatic issue(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                       input logic [31:0] rdata, input int nwait, input bit poke);
    int wait_left;
    wait_left    = nwait;
    bus_readdata = rdata;
    @(negedge clk);
    opcode   = op;
    eff_addr = addr;
    rt_data  = rt;
    op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    lat = -1; rd_cyc = 0; wr_cyc = 0; be_seen = '0; wd_seen = '0; ad_seen = '0;
    saw_done = 1'b0; saw_err = 1'b0; stable = 1'b1; res_seen = '0;
    for (int i = 1; i <= 30; i++) begin
      if (poke && i == 1) begin
        opcode = SB; eff_addr = 32'h0000_0300; rt_data = 32'h0000_00FF; op_valid = 1'b1;
      end else begin
        op_valid = 1'b0;
      end
      if (bus_read || bus_write) begin
        if (rd_cyc + wr_cyc == 0) begin
          be_seen = bus_byteenable; wd_seen = bus_writedata; ad_seen = bus_address;
        end else if (bus_byteenable !== be_seen || bus_writedata !== wd_seen ||
                     bus_address !== ad_seen) begin
          stable = 1'b0;
        end
        if (bus_read)  rd_cyc++;
        if (bus_write) wr_cyc++;
        bus_waitrequest = (wait_left > 0);
        if (wait_left > 0) wait_left--;
      end else begin
        bus_waitrequest = 1'b0;
      end
      if (done || addr_error) begin
        lat = i - 1; saw_done = done; saw_err = addr_error; res_seen = load_result;
        break;
      end
      @(negedge clk);
    end
    op_valid = 1'b0;
    @(negedge clk);
    pulse_ok = !done && !addr_error && !busy;
    quiet = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (bus_read || bus_write || done || addr_error || busy) quiet = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic check_load(input string tag, input logic [3:0] be, input logic [31:0] res, input int exp_lat);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " read cycles"}, 32'(rd_cyc), 32'(exp_lat - 2));
    check({tag, " no write"}, 32'(wr_cyc), 32'd0);
    check({tag, " byteenable"}, {28'd0, be_seen}, {28'd0, be});
    check({tag, " result"}, res_seen, res);
    check({tag, " done pulse"}, {31'd0, pulse_ok}, 32'd1);
  endtask

  task automatic check_store(input string tag, input logic [3:0] be, input logic [31:0] wd,
                             input logic [31:0] ad, input int exp_lat);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " write cycles"}, 32'(wr_cyc), 32'(exp_lat - 1));
    check({tag, " no read"}, 32'(rd_cyc), 32'd0);
    check({tag, " byteenable"}, {28'd0, be_seen}, {28'd0, be});
    check({tag, " writedata"}, wd_seen, wd);
    check({tag, " address"}, ad_seen, ad);
    check({tag, " stable"}, {31'd0, stable}, 32'd1);
    check({tag, " done pulse"}, {31'd0, pulse_ok}, 32'd1);
  endtask

  task automatic check_error(input string tag);
    check({tag, " addr_error"}, {31'd0, saw_err}, 32'd1);
    check({tag, " no done"}, {31'd0, saw_done}, 32'd0);
    check({tag, " latency"}, 32'(lat), 32'd1);
    check({tag, " no strobe"}, 32'(rd_cyc + wr_cyc), 32'd0);
    check({tag, " pulse"}, {31'd0, pulse_ok}, 32'd1);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, " ctrl"}, {26'd0, busy, done, addr_error, bus_read, bus_write, 1'b0}, 32'd0);
    check({tag, " be"}, {28'd0, bus_byteenable}, 32'd0);
    check({tag, " addr"}, bus_address, 32'd0);
    check({tag, " wdata"}, bus_writedata, 32'd0);
    check({tag, " result"}, load_result, 32'd0);
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; opcode = '0; eff_addr = '0; rt_data = '0;
    bus_waitrequest = 1'b0; bus_readdata = '0;
    #1;
    check_idle_zero("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    issue(SW, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, 0);
    check_store("sw", 4'b1111, 32'hDEAD_BEEF, 32'h0000_0100, 2);
    check("sw result untouched", load_result, 32'd0);

    issue(LB, 32'h0000_0103, 32'h0, 32'h1122_33F4, 0, 0);
    check_load("lb", 4'b1111, 32'hFFFF_FFF4, 3);
    issue(LBU, 32'h0000_0103, 32'h0, 32'h1122_33F4, 0, 0);
    check_load("lbu", 4'b1111, 32'h0000_00F4, 3);

    issue(LWL, 32'h0000_0101, 32'h1122_3344, 32'hAABB_CCDD, 0, 0);
    check_load("lwl", 4'b1110, 32'hBBCC_DD44, 3);
    issue(LWR, 32'h0000_0101, 32'h1122_3344, 32'hAABB_CCDD, 0, 0);
    check_load("lwr", 4'b0011, 32'h1122_AABB, 3);

    issue(LH, 32'h0000_0100, 32'h0, 32'h8001_2345, 0, 0);
    check_load("lh", 4'b1111, 32'hFFFF_8001, 3);
    issue(LHU, 32'h0000_0102, 32'h0, 32'h8001_F234, 0, 0);
    check_load("lhu", 4'b1111, 32'h0000_F234, 3);

    issue(SH, 32'h0000_0102, 32'h0000_BEEF, 32'h0, 3, 0);
    check_store("sh wait", 4'b1100, 32'h0000_BEEF, 32'h0000_0100, 5);
    check("sh result held", load_result, 32'h0000_F234);

    issue(SB, 32'h0000_0101, 32'h0000_55AA, 32'h0, 0, 0);
    check_store("sb", 4'b0010, 32'h00AA_0000, 32'h0000_0100, 2);

    issue(LW, 32'h0000_0104, 32'h0, 32'h1234_5678, 2, 1);
    check_load("lw poke", 4'b1111, 32'h1234_5678, 5);
    check("lw poke stable", {31'd0, stable}, 32'd1);
    check("lw poke addr", ad_seen, 32'h0000_0104);
    check("poke ignored", {31'd0, quiet}, 32'd1);

    issue(LW, 32'h0000_0102, 32'h0, 32'h0, 0, 0);
    check_error("lw misaligned");
    issue(SH, 32'h0000_0101, 32'h0, 32'h0, 0, 0);
    check_error("sh misaligned");
    issue(6'b111111, 32'h0000_0100, 32'h0, 32'h0, 0, 0);
    check_error("bad opcode");
    check("error result held", load_result, 32'h1234_5678);

    // Reset while a read is stalled: strobe must drop without waiting for an edge.
    @(negedge clk);
    opcode = LW; eff_addr = 32'h0000_0200; op_valid = 1'b1; bus_waitrequest = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    check("rst pre read", {31'd0, bus_read}, 32'd1);
    @(negedge clk);
    check("rst stalled read", {31'd0, bus_read}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst read drop", {31'd0, bus_read}, 32'd0);
    check("rst busy drop", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0; bus_waitrequest = 1'b0;
    @(negedge clk);
    check_idle_zero("post reset");

    issue(LBU, 32'h0000_0300, 32'h0, 32'h9A00_0000, 0, 0);
    check_load("lbu after reset", 4'b1111, 32'h0000_009A, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
